// File: rtl/pdp1_cpu_alu_mul.sv
`default_nettype none
// pdp1_cpu_alu_mul: 17x17 unsigned shift-add multiplier for the PDP-1 MUL magnitude path.
// Revision: 1.0
module pdp1_cpu_alu_mul (
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_start,
  input  logic [16:0] in_mcand,
  input  logic [16:0] in_mplier,
  output logic        out_busy,
  output logic        out_done,
  output logic [33:0] out_product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [16:0] mcand_q, mcand_d;
  logic [33:0] acc_q, acc_d;
  logic [33:0] product_q, product_d;
  logic [17:0] w_sum;
  logic [33:0] w_step;

  // acc holds {partial product, unretired multiplier bits}; one bit retires per step.
  always_comb begin
    w_sum  = {1'b0, acc_q[33:17]} + (acc_q[0] ? {1'b0, mcand_q} : 18'd0);
    w_step = {w_sum, acc_q[16:1]};
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          mcand_d = in_mcand;
          acc_d   = {17'd0, in_mplier};
          count_d = 5'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = w_step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd16) begin
          product_d = w_step;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q   <= ST_IDLE;
      count_q   <= 5'd0;
      mcand_q   <= 17'd0;
      acc_q     <= 34'd0;
      product_q <= 34'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign out_busy    = (state_q == ST_RUN);
  assign out_done    = (state_q == ST_DONE);
  assign out_product = product_q;

endmodule
`default_nettype wire

// File: doc/pdp1_cpu_alu_mul.md
PDP1_CPU_ALU_MUL -- requirements
Module: pdp1_cpu_alu_mul

Interface
REQ-001 Parameters: none; all widths are fixed by the PDP-1 MUL magnitude datapath.
REQ-002 in_clock  input  1  single clock; all state changes on its rising edge.
REQ-003 in_reset  input  1  reset, asynchronous and active-high.
REQ-004 in_start  input  1  request pulse; sampled only while the block is idle.
REQ-005 in_mcand  input  17  multiplicand magnitude (unsigned).
REQ-006 in_mplier  input  17  multiplier magnitude (unsigned).
REQ-007 out_busy  output  1  high while a multiply is in progress.
REQ-008 out_done  output  1  one-cycle completion pulse.
REQ-009 out_product  output  34  unsigned product; drives the AC:IO concatenation, AC in [33:17].

Function
REQ-010 The block SHALL compute out_product = in_mcand * in_mplier as unsigned 17x17->34-bit with no truncation or overflow; the CPU handles sign and ones'-complement.
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE: if in_start=1 at an edge, the block SHALL latch in_mcand and in_mplier, clear the partial product and the 5-bit step counter, and enter RUN; otherwise it stays in IDLE.
REQ-013 RUN: each edge SHALL retire exactly one multiplier bit, LSB first (shift-add: conditionally add the multiplicand to the upper partial, then shift right one bit), and increment the counter.
REQ-014 RUN SHALL last exactly 17 edges; on the edge retiring bit 16 (counter=16) the block SHALL load out_product with the final product and enter DONE.
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-016 Latency is fixed: out_done is high in the cycle beginning 17 clocks after the edge that sampled in_start.
REQ-017 There SHALL be no early termination for zero operands.
REQ-018 out_busy SHALL be 1 exactly while in RUN, i.e. 17 cycles per operation.
REQ-019 out_done SHALL be 1 exactly while in DONE, i.e. a single-cycle pulse.
REQ-020 out_product SHALL change only on the RUN->DONE edge (and at reset); it holds the last result through IDLE and the next RUN.
REQ-021 in_start asserted in RUN or DONE SHALL be ignored and not queued.
REQ-022 Operand inputs SHALL be ignored except on the accepting edge; changes during RUN do not affect the result.
REQ-023 The earliest back-to-back start is the cycle after out_done, giving 19 cycles per operation including the IDLE acceptance cycle.

Reset
REQ-024 in_reset=1 SHALL asynchronously force the FSM to IDLE and clear the counter, the partial product and the operand registers.
REQ-025 Output reset values SHALL be out_busy=0, out_done=0, out_product=34'h0.
REQ-026 Reset asserted during RUN SHALL abort the operation with no done pulse, and out_product SHALL read 0.
REQ-027 After reset deasserts, the first in_start SHALL be accepted at the first rising edge with in_reset=0.

Verification
REQ-028 Basic: start with mcand=5, mplier=3 -> out_busy high for 17 cycles; out_done one cycle, 17 clocks after the start edge; out_product=34'h0_0000_000F.
REQ-029 Maximum: mcand=17'h1FFFF, mplier=17'h1FFFF -> out_product=34'h3_FFFC_0001 with the same latency.
REQ-030 Zero: mcand=0, mplier=17'h12345 -> out_product=0 after the full 17-cycle RUN (no shortcut); the prior result holds until that edge.
REQ-031 Ignore: start 2x3; pulse in_start with 7x7 and change the operands at RUN cycle 5 -> result=6, a single done pulse, and no second operation starts.
REQ-032 Abort: start 1FFFFx2 and assert in_reset at RUN cycle 8 -> busy/done/product immediately 0; a fresh start 4x4 after release gives 16 at the standard latency.
REQ-033 Back-to-back: issue the second start in the cycle after done -> accepted; second done occurs exactly 19 cycles after the first done.
